// File: rtl/player_io_pkg.sv
// Shared definitions for the player input front-end.
//   NUM_PLAYERS  : number of player channels (fixed at 4)
//   SW_WIDTH     : switch bits per player
//   player_idx_t : 2-bit player index, PLAYER_P1..PLAYER_P4 = 0..3
//   arb_state_e  : buzzer arbitration FSM states
//   pick_lowest  : lowest-index set bit of a 4-bit request vector
package player_io_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned SW_WIDTH    = 8;

  typedef logic [1:0] player_idx_t;

  localparam player_idx_t PLAYER_P1 = 2'b00;
  localparam player_idx_t PLAYER_P2 = 2'b01;
  localparam player_idx_t PLAYER_P3 = 2'b10;
  localparam player_idx_t PLAYER_P4 = 2'b11;

  typedef enum logic [1:0] {
    StArmed,
    StLocked,
    StRearm
  } arb_state_e;

  // Lowest index wins among simultaneous requests; returns P1 when req is empty.
  function automatic player_idx_t pick_lowest(input logic [NUM_PLAYERS-1:0] req);
    player_idx_t idx;
    priority casez (req)
      4'b???1: idx = PLAYER_P1;
      4'b??10: idx = PLAYER_P2;
      4'b?100: idx = PLAYER_P3;
      4'b1000: idx = PLAYER_P4;
      default: idx = PLAYER_P1;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a stability counter.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with it; any agreeing sample restarts the count.
//   clk_i       : system clock
//   reset_i     : synchronous, active-high reset
//   btn_raw_i   : asynchronous raw button
//   btn_level_o : debounced level
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_raw_i,
  output logic btn_level_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q;
  logic            sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      meta_q  <= btn_raw_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign btn_level_o = level_q;

endmodule

// File: rtl/player_buzz_arbiter.sv
// Player buzzer front-end. Debounces four buttons, locks onto the first enabled
// press (lowest index on ties), captures that player's synchronised switches and
// holds the record for the CPU until acknowledged. After an ack, a new round only
// starts once every debounced button has been released.
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   btn_raw       : raw buttons, bit i = player i
//   sw_raw        : raw switches, [8i+7:8i] = player i
//   player_enable : per-player press enable
//   input_ack     : CPU consumed the record
//   input_valid   : record held and valid
//   first_player  : winning player index
//   switch_value  : winner's switches captured at the win
//   btn_level     : debounced button levels
module player_buzz_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NUM_PLAYERS     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_raw,
  input  logic [31:0] sw_raw,
  input  logic [3:0]  player_enable,
  input  logic        input_ack,
  output logic        input_valid,
  output logic [1:0]  first_player,
  output logic [7:0]  switch_value,
  output logic [3:0]  btn_level
);

  import player_io_pkg::*;

  logic [31:0]         sw_meta_q, sw_sync_q;
  logic [SW_WIDTH-1:0] sw_by_player [NUM_PLAYERS];
  logic [3:0]          level_prev_q;
  logic [3:0]          press;

  arb_state_e          state_q, state_d;
  player_idx_t         fp_q, fp_d;
  logic [SW_WIDTH-1:0] sw_q, sw_d;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i      (clk),
      .reset_i    (reset),
      .btn_raw_i  (btn_raw[g]),
      .btn_level_o(btn_level[g])
    );
    assign sw_by_player[g] = sw_sync_q[g*SW_WIDTH +: SW_WIDTH];
  end

  // One-cycle rising edge of the debounced level, gated by the live enable.
  assign press = btn_level & ~level_prev_q & player_enable;

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    sw_d    = sw_q;
    unique case (state_q)
      StArmed: begin
        if (|press) begin
          state_d = StLocked;
          fp_d    = pick_lowest(press);
          sw_d    = sw_by_player[fp_d];
        end
      end
      StLocked: begin
        // Ack takes priority; presses in this state are simply dropped.
        if (input_ack) state_d = StRearm;
      end
      StRearm: begin
        if (btn_level == 4'b0000) state_d = StArmed;
      end
      default: state_d = StArmed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      level_prev_q <= '0;
      state_q      <= StArmed;
      fp_q         <= PLAYER_P1;
      sw_q         <= '0;
    end else begin
      sw_meta_q    <= sw_raw;
      sw_sync_q    <= sw_meta_q;
      level_prev_q <= btn_level;
      state_q      <= state_d;
      fp_q         <= fp_d;
      sw_q         <= sw_d;
    end
  end

  assign input_valid  = (state_q == StLocked);
  assign first_player = fp_q;
  assign switch_value = sw_q;

endmodule

// File: tb/tb_player_buzz_arbiter.sv
module tb_player_buzz_arbiter;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_raw = '0;
  logic [31:0] sw_raw = '0;
  logic [3:0]  player_enable = 4'b1111;
  logic        input_ack = 1'b0;
  logic        input_valid;
  logic [1:0]  first_player;
  logic [7:0]  switch_value;
  logic [3:0]  btn_level;

  always #5 clk = ~clk;

  player_buzz_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .NUM_PLAYERS    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .sw_raw       (sw_raw),
    .player_enable(player_enable),
    .input_ack    (input_ack),
    .input_valid  (input_valid),
    .first_player (first_player),
    .switch_value (switch_value),
    .btn_level    (btn_level)
  );

  typedef struct packed {
    logic [1:0] fp;
    logic [7:0] sw;
  } rec_t;

  rec_t model_q[$];
  rec_t dir_q[$];
  logic dir_phase = 1'b1;
  logic done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: raw inputs reach the debouncer two edges late; a level flips
  // after D consecutive disagreeing samples; the first enabled rising level wins a
  // round, which ends with ack and restarts only once all buttons are released.
  logic [3:0]  m_s1, m_s2, m_lvl, m_prev;
  logic [31:0] m_sw1, m_sw2;
  int          m_run [4];
  int          m_mode;  // 0 waiting for a press, 1 record held, 2 waiting for release
  logic [1:0]  m_fp;
  logic [7:0]  m_sw;

  always @(posedge clk) begin
    logic [3:0] rise;
    logic [3:0] nxt;
    int w;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
      m_sw1 = '0; m_sw2 = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = 0; m_fp = '0; m_sw = '0;
    end else begin
      rise = m_lvl & ~m_prev & player_enable;
      if (m_mode == 0) begin
        if (rise != 0) begin
          w = 3;
          for (int i = 3; i >= 0; i--) if (rise[i]) w = i;
          m_fp = 2'(w);
          m_sw = m_sw2[8*w +: 8];
          m_mode = 1;
          model_q.push_back('{fp: m_fp, sw: m_sw});
        end
      end else if (m_mode == 1) begin
        if (input_ack) m_mode = 2;
      end else begin
        if (m_lvl == 4'b0000) m_mode = 0;
      end
      nxt = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == int'(D)) begin
            nxt[i] = ~m_lvl[i];
            m_run[i] = 0;
          end
        end
      end
      m_prev = m_lvl;
      m_lvl = nxt;
      m_s2 = m_s1; m_s1 = btn_raw;
      m_sw2 = m_sw1; m_sw1 = sw_raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: all comparisons happen here.
  logic seen_valid = 1'b0;
  always @(negedge clk) begin
    rec_t r;
    if (done) begin
      chk("model_queue_drained", 32'(model_q.size()), 0);
      chk("directed_queue_drained", 32'(dir_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else begin
      chk("input_valid", 32'(input_valid), 32'(m_mode == 1));
      chk("btn_level", 32'(btn_level), 32'(m_lvl));
      chk("first_player", 32'(first_player), 32'(m_fp));
      chk("switch_value", 32'(switch_value), 32'(m_sw));
      if (input_valid && !seen_valid) begin
        if (model_q.size() == 0) begin
          chk("record_expected_by_model", 1, 0);
        end else begin
          r = model_q.pop_front();
          chk("record_player", 32'(first_player), 32'(r.fp));
          chk("record_switches", 32'(switch_value), 32'(r.sw));
        end
        if (dir_phase) begin
          if (dir_q.size() == 0) begin
            chk("record_expected_by_directed", 1, 0);
          end else begin
            r = dir_q.pop_front();
            chk("directed_player", 32'(first_player), 32'(r.fp));
            chk("directed_switches", 32'(switch_value), 32'(r.sw));
          end
        end
      end
      seen_valid = input_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    input_ack = 1'b1;
    step(1);
    input_ack = 1'b0;
  endtask

  task automatic idle();
    btn_raw = '0;
    step(8);
    ack_pulse();
    step(8);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // Clean press; switch change while locked must not disturb the record.
    sw_raw = 32'h0000_00A5;
    btn_raw = 4'b0001;
    dir_q.push_back('{fp: 2'd0, sw: 8'hA5});
    step(7);
    sw_raw[7:0] = 8'h5A;
    step(3);
    idle();

    // Glitch shorter than the debounce window.
    btn_raw = 4'b0100;
    step(3);
    btn_raw = '0;
    step(10);

    // Simultaneous press: lower index wins.
    sw_raw = 32'h1122_3C44;
    btn_raw = 4'b1010;
    dir_q.push_back('{fp: 2'd1, sw: 8'h3C});
    step(7);
    ack_pulse();
    idle();

    // Lockout, ack, held button blocks re-arm, then a fresh press.
    sw_raw = 32'hE177_0000;
    btn_raw = 4'b0100;
    dir_q.push_back('{fp: 2'd2, sw: 8'h77});
    step(7);
    btn_raw = 4'b0101;
    step(8);
    ack_pulse();
    btn_raw = 4'b0001;
    step(15);
    btn_raw = '0;
    step(10);
    btn_raw = 4'b1000;
    dir_q.push_back('{fp: 2'd3, sw: 8'hE1});
    step(8);
    idle();

    // Enable mask skips player 0.
    player_enable = 4'b1110;
    sw_raw = 32'hAABB_CCDD;
    btn_raw = 4'b0101;
    dir_q.push_back('{fp: 2'd2, sw: 8'hBB});
    step(8);
    idle();
    player_enable = 4'b1111;

    // Reset while locked; the held button re-debounces and wins again.
    sw_raw = 32'h0000_9900;
    btn_raw = 4'b0010;
    dir_q.push_back('{fp: 2'd1, sw: 8'h99});
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dir_q.push_back('{fp: 2'd1, sw: 8'h99});
    step(8);
    idle();

    // Randomised traffic.
    dir_phase = 1'b0;
    begin
      int hold [4];
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (hold[i] == 0) begin
            btn_raw[i] = 1'($urandom_range(0, 1));
            hold[i] = $urandom_range(1, 14);
          end else begin
            hold[i]--;
          end
        end
        if ($urandom_range(0, 3) == 0) sw_raw = $urandom;
        input_ack = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) player_enable = 4'($urandom_range(0, 15));
        reset = ($urandom_range(0, 499) == 0);
        step(1);
      end
    end
    reset = 1'b0;
    input_ack = 1'b0;
    btn_raw = '0;
    step(4);
    done = 1'b1;
  end

endmodule
